// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the ALU: decodes one instruction, feeds operands from a 32x32 RF, writes the result back.
// Latency: accept at E0, ALU inputs driven in the cycle after E0, writeback strobe one cycle later, RF updated at E2 (3 cycles per instruction).
// Backpressure: in_ready is high only in IDLE; an illegal word is consumed in one cycle and the controller stays ready.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/instr instruction handshake;
//        alu_op1/alu_op2/alu_sel to the ALU, alu_res from it; wb_valid/wb_addr/wb_data writeback strobe;
//        err_illegal/err_div0 one-cycle error pulses; dbg_rd_addr/dbg_rd_data combinational RF debug port.
// Optional feature macro: ALU_DIV0_GUARD_EN (divide-by-zero result override and err_div0 pulse).
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_res,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err_illegal,
    output logic        err_div0,
    input  logic [4:0]  dbg_rd_addr,
    output logic [31:0] dbg_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [15:0] imm_q, imm_d;
    logic [3:0]  sel_q, sel_d;
    logic [4:0]  dest_q, dest_d;
    logic        use_imm_q, use_imm_d;
    logic [31:0] result_q, result_d;
    logic        err_illegal_q, err_illegal_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic        dec_legal;
    logic [3:0]  dec_sel;
    logic [4:0]  dec_dest;
    logic        dec_use_imm;
    logic [31:0] op1_raw;
    logic [31:0] op2_raw;

    // Instruction decode, evaluated on the word presented at the handshake.
    always_comb begin
        dec_legal   = 1'b0;
        dec_sel     = 4'd0;
        dec_dest    = 5'd0;
        dec_use_imm = 1'b0;
        if (instr[31:26] == 6'h00) begin
            dec_dest = instr[15:11];
            case (instr[5:0])
                6'h20: begin dec_legal = 1'b1; dec_sel = 4'd1; end
                6'h22: begin dec_legal = 1'b1; dec_sel = 4'd2; end
                6'h18: begin dec_legal = 1'b1; dec_sel = 4'd3; end
                6'h1A: begin dec_legal = 1'b1; dec_sel = 4'd4; end
                6'h25: begin dec_legal = 1'b1; dec_sel = 4'd5; end
                6'h26: begin dec_legal = 1'b1; dec_sel = 4'd6; end
                6'h00: begin dec_legal = 1'b1; dec_sel = 4'd7; end
                6'h2A: begin dec_legal = 1'b1; dec_sel = 4'd8; end
                default: dec_legal = 1'b0;
            endcase
        end else if (instr[31:26] == 6'h08) begin
            dec_legal   = 1'b1;
            dec_sel     = 4'd1;
            dec_dest    = instr[20:16];
            dec_use_imm = 1'b1;
        end
    end

    // rf_q[0] is never written, so register 0 reads 0 without a read-side mux.
    assign op1_raw = rf_q[rs_q];
    assign op2_raw = use_imm_q ? {{16{imm_q[15]}}, imm_q} : rf_q[rt_q];

`ifdef ALU_DIV0_GUARD_EN
    logic div0_q, div0_d;
`endif

    always_comb begin
        state_d       = state_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        imm_d         = imm_q;
        sel_d         = sel_q;
        dest_d        = dest_q;
        use_imm_d     = use_imm_q;
        result_d      = result_q;
        err_illegal_d = 1'b0;
        rf_d          = rf_q;
`ifdef ALU_DIV0_GUARD_EN
        div0_d        = div0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (dec_legal) begin
                        rs_d      = instr[25:21];
                        rt_d      = instr[20:16];
                        imm_d     = instr[15:0];
                        sel_d     = dec_sel;
                        dest_d    = dec_dest;
                        use_imm_d = dec_use_imm;
                        state_d   = S_EXEC;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                result_d = alu_res;
`ifdef ALU_DIV0_GUARD_EN
                div0_d = 1'b0;
                if (sel_q == 4'd4 && op2_raw == 32'd0) begin
                    result_d = 32'hFFFF_FFFF;
                    div0_d   = 1'b1;
                end
`endif
                state_d = S_WB;
            end
            S_WB: begin
                if (dest_q != 5'd0) begin
                    rf_d[dest_q] = result_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rs_q          <= 5'd0;
            rt_q          <= 5'd0;
            imm_q         <= 16'd0;
            sel_q         <= 4'd0;
            dest_q        <= 5'd0;
            use_imm_q     <= 1'b0;
            result_q      <= 32'd0;
            err_illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            imm_q         <= imm_d;
            sel_q         <= sel_d;
            dest_q        <= dest_d;
            use_imm_q     <= use_imm_d;
            result_q      <= result_d;
            err_illegal_q <= err_illegal_d;
            rf_q          <= rf_d;
        end
    end

`ifdef ALU_DIV0_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div0_q <= 1'b0;
        end else begin
            div0_q <= div0_d;
        end
    end
    assign err_div0 = (state_q == S_WB) && div0_q;
`else
    assign err_div0 = 1'b0;
`endif

    // ALU inputs are held at zero outside EXEC so the ALU idles on sel 0.
    always_comb begin
        in_ready    = (state_q == S_IDLE);
        alu_op1     = 32'd0;
        alu_op2     = 32'd0;
        alu_sel     = 4'd0;
        wb_valid    = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        err_illegal = err_illegal_q;
        dbg_rd_data = rf_q[dbg_rd_addr];
        if (state_q == S_EXEC) begin
            alu_op1 = op1_raw;
            alu_op2 = op2_raw;
            alu_sel = sel_q;
        end
        if (state_q == S_WB) begin
            wb_valid = 1'b1;
            wb_addr  = dest_q;
            wb_data  = result_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_sel;
    logic [31:0] alu_res;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_illegal;
    logic        err_div0;
    logic [4:0]  dbg_rd_addr;
    logic [31:0] dbg_rd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        div0;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_sel     (alu_sel),
        .alu_res     (alu_res),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err_illegal (err_illegal),
        .err_div0    (err_div0),
        .dbg_rd_addr (dbg_rd_addr),
        .dbg_rd_data (dbg_rd_data)
    );

    // Behavioural ALU: the environment the controller drives.
    always_comb begin
        case (alu_sel)
            4'd1:    alu_res = alu_op1 + alu_op2;
            4'd2:    alu_res = alu_op1 - alu_op2;
            4'd3:    alu_res = alu_op1 * alu_op2;
            4'd4:    alu_res = (alu_op2 == 32'd0) ? 32'd0 : alu_op1 / alu_op2;
            4'd5:    alu_res = alu_op1 | alu_op2;
            4'd6:    alu_res = alu_op1 ^ alu_op2;
            4'd7:    alu_res = alu_op1;
            4'd8:    alu_res = {31'd0, alu_op1 < alu_op2};
            default: alu_res = 32'd0;
        endcase
    end

    // Scoreboard consumer: every writeback strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, required no writeback", wb_addr, wb_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (wb_addr !== e.addr || wb_data !== e.data || err_div0 !== e.div0) begin
                    errors++;
                    $display("FAIL wb_data: got addr=%0d data=%h div0=%b, required addr=%0d data=%h div0=%b",
                             wb_addr, wb_data, err_div0, e.addr, e.data, e.div0);
                end
            end
        end else if (rst_n === 1'b1 && err_div0 !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL div0_outside_wb: got err_div0=%b, required 0", err_div0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    // Issues one legal instruction and follows it through EXEC and WB.
    task automatic run_instr(input string name, input logic [31:0] w, input logic [3:0] sel,
                             input logic [4:0] dest, input logic [31:0] data,
                             input logic div0, input logic [31:0] rf_after);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        instr    = w;
        e.addr = dest; e.data = data; e.div0 = div0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr    = $urandom;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || alu_sel !== sel || wb_valid !== 1'b0 || err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s_exec: got rdy=%b sel=%0d wb=%b ill=%b, required rdy=0 sel=%0d wb=0 ill=0",
                     name, in_ready, alu_sel, wb_valid, err_illegal, sel);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b1 || alu_sel !== 4'd0) begin
            errors++;
            $display("FAIL %s_wb: got rdy=%b wb=%b sel=%0d, required rdy=0 wb=1 sel=0",
                     name, in_ready, wb_valid, alu_sel);
        end
        @(negedge clk);
        dbg_rd_addr = dest;
        #1;
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || dbg_rd_data !== rf_after) begin
            errors++;
            $display("FAIL %s_done: got rdy=%b wb=%b rf=%h, required rdy=1 wb=0 rf=%h",
                     name, in_ready, wb_valid, dbg_rd_data, rf_after);
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instr       = 32'd0;
        dbg_rd_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || alu_op1 !== 32'd0 || alu_op2 !== 32'd0 ||
            alu_sel !== 4'd0 || wb_addr !== 5'd0 || wb_data !== 32'd0 || err_illegal !== 1'b0 ||
            err_div0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b wb=%b op1=%h op2=%h sel=%0d wba=%0d wbd=%h ill=%b d0=%b, required rdy=1 rest 0",
                     in_ready, wb_valid, alu_op1, alu_op2, alu_sel, wb_addr, wb_data, err_illegal, err_div0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dbg_rd_addr = i[4:0];
            #1;
            checks++;
            if (dbg_rd_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_rf: r%0d got %h, required 0", i, dbg_rd_data);
            end
        end
    endtask

    task automatic test_addi;
        run_instr("addi_r1", addi(5'd0, 5'd1, 16'd5),      4'd1, 5'd1, 32'd5,        1'b0, 32'd5);
        run_instr("addi_r2", addi(5'd0, 5'd2, 16'hFFFD),   4'd1, 5'd2, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFD);
    endtask

    task automatic test_rtype;
        run_instr("add",  rtype(5'd1, 5'd2, 5'd3,  6'h20), 4'd1, 5'd3,  32'd2,        1'b0, 32'd2);
        run_instr("sub",  rtype(5'd1, 5'd2, 5'd4,  6'h22), 4'd2, 5'd4,  32'd8,        1'b0, 32'd8);
        run_instr("slt",  rtype(5'd2, 5'd1, 5'd5,  6'h2A), 4'd8, 5'd5,  32'd0,        1'b0, 32'd0);
        run_instr("or",   rtype(5'd1, 5'd2, 5'd6,  6'h25), 4'd5, 5'd6,  32'hFFFFFFFD, 1'b0, 32'hFFFFFFFD);
        run_instr("xor",  rtype(5'd1, 5'd2, 5'd7,  6'h26), 4'd6, 5'd7,  32'hFFFFFFF8, 1'b0, 32'hFFFFFFF8);
        run_instr("mul",  rtype(5'd1, 5'd2, 5'd10, 6'h18), 4'd3, 5'd10, 32'hFFFFFFF1, 1'b0, 32'hFFFFFFF1);
        run_instr("pass", rtype(5'd1, 5'd0, 5'd11, 6'h00), 4'd7, 5'd11, 32'd5,        1'b0, 32'd5);
    endtask

    task automatic test_illegal;
        logic [31:0] bad [2];
        bad[0] = {6'h23, 5'd1, 5'd2, 16'h0004};
        bad[1] = rtype(5'd1, 5'd1, 5'd2, 6'h21);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr    = bad[k];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (err_illegal !== 1'b1 || in_ready !== 1'b1 || wb_valid !== 1'b0 || alu_sel !== 4'd0) begin
                errors++;
                $display("FAIL illegal_pulse%0d: got ill=%b rdy=%b wb=%b sel=%0d, required ill=1 rdy=1 wb=0 sel=0",
                         k, err_illegal, in_ready, wb_valid, alu_sel);
            end
            @(negedge clk);
            dbg_rd_addr = 5'd2;
            #1;
            checks++;
            if (err_illegal !== 1'b0 || wb_valid !== 1'b0 || dbg_rd_data !== 32'hFFFFFFFD) begin
                errors++;
                $display("FAIL illegal_after%0d: got ill=%b wb=%b r2=%h, required ill=0 wb=0 r2=fffffffd",
                         k, err_illegal, wb_valid, dbg_rd_data);
            end
        end
        run_instr("add_r0", rtype(5'd1, 5'd1, 5'd0, 6'h20), 4'd1, 5'd0, 32'd10, 1'b0, 32'd0);
    endtask

    task automatic test_div;
`ifdef ALU_DIV0_GUARD_EN
        run_instr("div0", rtype(5'd1, 5'd0, 5'd8, 6'h1A), 4'd4, 5'd8, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF);
`else
        run_instr("div0", rtype(5'd1, 5'd0, 5'd8, 6'h1A), 4'd4, 5'd8, 32'd0, 1'b0, 32'd0);
`endif
        run_instr("div", rtype(5'd1, 5'd1, 5'd12, 6'h1A), 4'd4, 5'd12, 32'd1, 1'b0, 32'd1);
    endtask

    task automatic test_reset_mid_exec;
        @(negedge clk);
        in_valid = 1'b1;
        instr    = rtype(5'd1, 5'd1, 5'd9, 6'h20);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_sel !== 4'd1 || alu_op1 !== 32'd5) begin
            errors++;
            $display("FAIL rst_mid_exec: got sel=%0d op1=%h, required sel=1 op1=5", alu_sel, alu_op1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || alu_sel !== 4'd0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got rdy=%b sel=%0d wb=%b, required rdy=1 sel=0 wb=0",
                     in_ready, alu_sel, wb_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        dbg_rd_addr = 5'd9;
        #1;
        checks++;
        if (dbg_rd_data !== 32'd0 || in_ready !== 1'b1 || err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_r9: got r9=%h rdy=%b ill=%b, required r9=0 rdy=1 ill=0",
                     dbg_rd_data, in_ready, err_illegal);
        end
        dbg_rd_addr = 5'd1;
        #1;
        checks++;
        if (dbg_rd_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_r1: got %h, required 0", dbg_rd_data);
        end
        checks++;
        if (sb_q.size() != 1) begin
            errors++;
            $display("FAIL rst_mid_sb: got %0d pending, required 1 (dropped instr)", sb_q.size());
        end
        sb_q.delete();
        run_instr("post_rst", addi(5'd0, 5'd1, 16'd7), 4'd1, 5'd1, 32'd7, 1'b0, 32'd7);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_illegal();
        test_div();
        begin
            exp_t e;
            e.addr = 5'd9; e.data = 32'd10; e.div0 = 1'b0;
            sb_q.push_back(e);
        end
        test_reset_mid_exec();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/writeback controller that sits directly upstream of the ALU in the execute path. It accepts one MIPS-style instruction word per valid/ready handshake and decodes it to a 4-bit ALU select. It supplies the two operands from an internal 32x32 register file, captures the ALU result and writes it back. It is the sole driver of the ALU's `op1`/`op2`/`sel` inputs and the sole consumer of `res`.

## Interface
- No parameters; datapath fixed at 32 bits, 32 registers, to match the ALU.
- `clk  in  1`  rising-edge clock
- `rst_n  in  1`  asynchronous, active-low reset
- `in_valid  in  1`  instruction word valid
- `in_ready  out  1`  controller can accept; high only in IDLE
- `instr  in  32`  instruction word
- `alu_op1  out  32`  to ALU `op1`
- `alu_op2  out  32`  to ALU `op2`
- `alu_sel  out  4`  to ALU `sel`
- `alu_res  in  32`  from ALU `res`
- `wb_valid  out  1`  one-cycle writeback strobe
- `wb_addr  out  5`  destination register
- `wb_data  out  32`  written value
- `err_illegal  out  1`  one-cycle pulse on an unsupported instruction
- `err_div0  out  1`  one-cycle pulse on divide-by-zero; see Configuration
- `dbg_rd_addr  in  5`  debug register read address
- `dbg_rd_data  out  32`  combinational `rf[dbg_rd_addr]`

## Operation
- Instruction fields: `op=[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `rd=[15:11]`, `funct=[5:0]`, `imm=[15:0]`.
- R-type (`op=0`), destination `rd`, `op2=rf[rt]`. funct to sel:
  - 0x20 (add) → 1
  - 0x22 (sub) → 2
  - 0x18 (mul) → 3
  - 0x1A (div) → 4
  - 0x25 (or) → 5
  - 0x26 (xor) → 6
  - 0x00 (pass) → 7
  - 0x2A (slt) → 8
- ADDI (`op=0x08`): sel 1, destination `rt`, `op2` = sign-extended `imm`.
- Any other op/funct is illegal: no state change except the `err_illegal` pulse, and no writeback.
- `op1=rf[rs]` in all cases. Register 0 reads 0 and ignores writes; `wb_valid` still pulses when the destination is 0.
- FSM:
  - IDLE → EXEC on an accepted legal instruction. Fields, decoded sel and destination are latched.
  - EXEC → WB unconditionally. `alu_res` is captured into the result register.
  - WB → IDLE unconditionally. `rf[dest]` is written at the exit edge.
- Outside EXEC, `alu_op1`, `alu_op2` and `alu_sel` are all 0, so the ALU sees sel 0.
- The register file is combinationally read during EXEC. No hazard logic is needed: the next accept cannot occur before the prior write completes.

## Timing
- Handshake occurs at the edge where `in_valid & in_ready`. `instr` need only be stable at that edge.
- Accept at edge E0:
  - EXEC cycle follows E0; ALU inputs are driven.
  - E1 captures the result.
  - WB cycle: `wb_valid=1` with `wb_addr` and `wb_data`.
  - E2 writes the register file and returns to IDLE.
- Throughput is one instruction per 3 cycles. The earliest next accept is E3.
- An illegal instruction accepted at E0 pulses `err_illegal` in the cycle after E0. The FSM stays in IDLE, so `in_ready` stays high.
- Reset values: state IDLE, all 32 registers 0, `in_ready=1`, all other outputs 0.
- Reset asserted mid-operation: the in-flight instruction is dropped with no writeback and no error pulse. The register file is cleared.
- `dbg_rd_data` is purely combinational. It shows the new value in the cycle after E2.

## Configuration
- `ALU_DIV0_GUARD_EN` defined: for sel 4 with `alu_op2==0`, the captured result is 32'hFFFFFFFF instead of `alu_res`. `err_div0` pulses during the WB cycle of that instruction.
- Not defined: `alu_res` is written as-is, and `err_div0` is tied 0.

## Test plan
- Reset, then `dbg_rd_addr` sweep 0..31 → all reads 0; `in_ready=1`, `wb_valid=0`.
- ADDI r1,r0,5 then ADDI r2,r0,-3 → `wb_valid` on cycle E0+2 each, with `wb_data`=5 and 0xFFFFFFFD; `in_ready` is low for exactly 2 cycles after each accept.
- With r1=5, r2=-3: add r3,r1,r2 → r3=2; sub r4,r1,r2 → 8; slt r5,r2,r1 → 0 (unsigned compare); or r6 → 0xFFFFFFFD; xor r7 → 0xFFFFFFF8.
- instr with op=0x23 → `err_illegal` high for 1 cycle, no `wb_valid`, register file unchanged; add r0,r1,r1 → `wb_valid` with data 10, r0 still reads 0.
- div r8,r1,r0 with `ALU_DIV0_GUARD_EN` → r8=0xFFFFFFFF and `err_div0` pulse; without the macro → `err_div0` stays 0.
- Assert `rst_n` low during EXEC of add r9,r1,r1 → no `wb_valid`, r9=0, r1=0 after release; FSM is in IDLE.
